// File: rtl/inst_fetch_responder.sv
// Instruction-side fetch responder: single-entry fetch buffer in front of a
// variable-latency memory bus, with stall request, bounded wait and flush.
module inst_fetch_responder #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic [31:0] addr,
    input  logic        flush,
    output logic [31:0] inst,
    output logic        stallreq,
    output logic        fetch_err,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state;
    logic             buf_valid;
    logic             buf_err;
    logic [29:0]      buf_word;
    logic [31:0]      buf_data;
    logic [29:0]      req_word;
    logic [CNT_W-1:0] cnt;
    logic             hit;
    logic             wait_done;

    // Byte-offset bits of the fetch address play no part in the lookup.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^addr[1:0];

    assign hit       = buf_valid && (buf_word == addr[31:2]);
    assign wait_done = (cnt == CNT_LAST);

    // Fetch FSM, buffer and bus request registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            buf_valid <= 1'b0;
            buf_err   <= 1'b0;
            buf_word  <= '0;
            buf_data  <= '0;
            req_word  <= '0;
            cnt       <= '0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ce && !hit && !flush) begin
                        state    <= REQ;
                        req_word <= addr[31:2];
                        cnt      <= '0;
                        mem_req  <= 1'b1;
                        mem_addr <= {addr[31:2], 2'b00};
                    end
                end
                REQ: begin
                    cnt <= cnt + CNT_W'(1);
                    if (mem_ack) begin
                        if (!flush) begin
                            buf_word  <= req_word;
                            buf_data  <= mem_rdata;
                            buf_valid <= 1'b1;
                            buf_err   <= 1'b0;
                        end
                        state   <= IDLE;
                        mem_req <= 1'b0;
                    end else if (wait_done) begin
                        // Wait budget spent: abandon even if a flush arrives now.
                        if (!flush) begin
                            buf_word  <= req_word;
                            buf_data  <= '0;
                            buf_valid <= 1'b1;
                            buf_err   <= 1'b1;
                        end
                        state   <= IDLE;
                        mem_req <= 1'b0;
                    end else if (flush) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Request stays up until the bus answers or the wait expires.
                    cnt <= cnt + CNT_W'(1);
                    if (mem_ack || wait_done) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
            // Flush wins over any fill on the same edge.
            if (flush) begin
                buf_valid <= 1'b0;
                buf_err   <= 1'b0;
            end
        end
    end

    // Pipeline-facing outputs, forced quiet while reset is held.
    always_comb begin
        inst      = '0;
        stallreq  = 1'b0;
        fetch_err = 1'b0;
        if (rst && ce) begin
            if (hit) begin
                inst      = buf_data;
                fetch_err = buf_err;
            end else begin
                stallreq = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_responder.sv
// Bench for inst_fetch_responder: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_inst_fetch_responder;

    localparam int unsigned TO = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic [31:0] addr;
    logic        flush;
    logic [31:0] inst;
    logic        stallreq;
    logic        fetch_err;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    inst_fetch_responder #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .addr      (addr),
        .flush     (flush),
        .inst      (inst),
        .stallreq  (stallreq),
        .fetch_err (fetch_err),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge, return at the falling edge.
    task automatic step(input logic r, input logic c, input logic [31:0] a,
                        input logic f, input logic k, input logic [31:0] d);
        @(posedge clk);
        #1;
        rst = r; ce = c; addr = a; flush = f; mem_ack = k; mem_rdata = d;
        @(negedge clk);
    endtask

    // ---------------- behavioural model ----------------
    // Buffer contents, plus one outstanding bus fetch that is either still
    // wanted (keep) or abandoned by a flush, and how long it has waited.
    logic        m_bv, m_be, m_busy, m_keep;
    logic [29:0] m_ba, m_fa;
    logic [31:0] m_bd;
    int          m_wait;
    logic        e_hit, e_stall, e_err, e_req;
    logic [31:0] e_inst;

    always @(negedge clk) begin
        if (!rst) begin
            m_bv = 1'b0; m_be = 1'b0; m_ba = '0; m_bd = '0;
            m_busy = 1'b0; m_keep = 1'b0; m_fa = '0; m_wait = 0;
            e_inst = '0; e_stall = 1'b0; e_err = 1'b0; e_req = 1'b0; e_hit = 1'b0;
        end else begin
            e_hit   = m_bv && (m_ba == addr[31:2]);
            e_inst  = (ce && e_hit) ? m_bd : 32'h0;
            e_err   = ce && e_hit && m_be;
            e_stall = ce && !e_hit;
            e_req   = m_busy;
        end
        check("model.inst",      inst,      e_inst);
        check("model.stallreq",  32'(stallreq),  32'(e_stall));
        check("model.fetch_err", 32'(fetch_err), 32'(e_err));
        check("model.mem_req",   32'(mem_req),   32'(e_req));
        if (!rst)
            check("model.mem_addr_rst", mem_addr, 32'h0);
        else if (e_req)
            check("model.mem_addr", mem_addr, {m_fa, 2'b00});

        // advance the model across the coming rising edge
        if (rst) begin
            if (!m_busy) begin
                if (!flush && ce && !e_hit) begin
                    m_busy = 1'b1; m_keep = 1'b1; m_fa = addr[31:2]; m_wait = 0;
                end
            end else begin
                if (mem_ack) begin
                    if (m_keep && !flush) begin
                        m_bv = 1'b1; m_be = 1'b0; m_ba = m_fa; m_bd = mem_rdata;
                    end
                    m_busy = 1'b0;
                end else if (m_wait + 1 == int'(TO)) begin
                    if (m_keep && !flush) begin
                        m_bv = 1'b1; m_be = 1'b1; m_ba = m_fa; m_bd = 32'h0;
                    end
                    m_busy = 1'b0;
                end else begin
                    m_wait = m_wait + 1;
                end
                if (flush) m_keep = 1'b0;
            end
            if (flush) begin
                m_bv = 1'b0; m_be = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    int          n_stall, n_req;
    logic        rr, rc, rf, rk;
    logic [31:0] ra;

    initial begin
        rst = 1'b0; ce = 1'b0; addr = '0; flush = 1'b0; mem_ack = 1'b0; mem_rdata = '0;

        // reset holds outputs quiet even with ce high
        step(0, 1, 32'h0, 0, 0, 32'h0);
        check("rst.stallreq", 32'(stallreq), 32'h0);
        check("rst.inst", inst, 32'h0);
        check("rst.mem_req", 32'(mem_req), 32'h0);

        // zero-wait fetch of 0x0
        step(1, 1, 32'h0, 0, 0, 32'h0);
        check("t1.c0.stallreq", 32'(stallreq), 32'h1);
        check("t1.c0.mem_req", 32'(mem_req), 32'h0);
        step(1, 1, 32'h0, 0, 1, 32'h3401_0020);
        check("t1.c1.mem_req", 32'(mem_req), 32'h1);
        check("t1.c1.mem_addr", mem_addr, 32'h0);
        check("t1.c1.stallreq", 32'(stallreq), 32'h1);
        step(1, 1, 32'h0, 0, 0, 32'h0);
        check("t1.c2.inst", inst, 32'h3401_0020);
        check("t1.c2.stallreq", 32'(stallreq), 32'h0);

        // 0x4 with ack delayed 5 cycles (lands on the last cycle of the wait budget)
        n_stall = 0; n_req = 0;
        for (int i = 0; i < 8; i++) begin
            step(1, 1, 32'h4, 0, (i == 6), 32'hDEAD_0004);
            if (stallreq) n_stall++;
            if (mem_req) n_req++;
        end
        check("t2.stall_cycles", 32'(n_stall), 32'd7);
        check("t2.req_cycles", 32'(n_req), 32'd6);
        check("t2.inst", inst, 32'hDEAD_0004);
        check("t2.mem_req_after", 32'(mem_req), 32'h0);
        step(1, 0, 32'h4, 0, 0, 32'h0);
        check("t2.ce0.inst", inst, 32'h0);
        step(1, 1, 32'h4, 0, 0, 32'h0);
        check("t2.refetch.stallreq", 32'(stallreq), 32'h0);
        check("t2.refetch.inst", inst, 32'hDEAD_0004);
        step(1, 1, 32'h4, 0, 0, 32'h0);
        check("t2.refetch.mem_req", 32'(mem_req), 32'h0);

        // 0x8 never acked: timeout substitutes a NOP with fetch_err
        n_req = 0;
        for (int i = 0; i < 8; i++) begin
            step(1, 1, 32'h8, 0, 0, 32'h0);
            if (mem_req) n_req++;
        end
        check("t3.req_cycles", 32'(n_req), 32'(TO));
        check("t3.inst", inst, 32'h0);
        check("t3.fetch_err", 32'(fetch_err), 32'h1);
        check("t3.stallreq", 32'(stallreq), 32'h0);
        step(1, 1, 32'hC, 0, 0, 32'h0);
        check("t3.c.fetch_err", 32'(fetch_err), 32'h0);
        check("t3.c.stallreq", 32'(stallreq), 32'h1);
        step(1, 1, 32'hC, 0, 1, 32'h1111_000C);
        check("t3.c.mem_addr", mem_addr, 32'hC);
        step(1, 1, 32'hC, 0, 0, 32'h0);
        check("t3.c.inst", inst, 32'h1111_000C);

        // flush during the wait for 0x10: request held to ack, data dropped, refetch
        step(1, 1, 32'h10, 0, 0, 32'h0);
        step(1, 1, 32'h10, 0, 0, 32'h0);
        step(1, 1, 32'h10, 1, 0, 32'h0);
        check("t4.flush.mem_req", 32'(mem_req), 32'h1);
        step(1, 1, 32'h10, 0, 0, 32'h0);
        check("t4.drain.mem_req", 32'(mem_req), 32'h1);
        step(1, 1, 32'h10, 0, 1, 32'h0BAD_0010);
        check("t4.ack.mem_req", 32'(mem_req), 32'h1);
        step(1, 1, 32'h10, 0, 0, 32'h0);
        check("t4.after.stallreq", 32'(stallreq), 32'h1);
        check("t4.after.inst", inst, 32'h0);
        step(1, 1, 32'h10, 0, 1, 32'h2222_0010);
        check("t4.refetch.mem_req", 32'(mem_req), 32'h1);
        check("t4.refetch.mem_addr", mem_addr, 32'h10);
        step(1, 1, 32'h10, 0, 0, 32'h0);
        check("t4.refetch.inst", inst, 32'h2222_0010);

        // flush on a hit, then an ack coinciding with flush is discarded
        step(1, 1, 32'h14, 0, 0, 32'h0);
        step(1, 1, 32'h14, 0, 1, 32'h3333_0014);
        step(1, 1, 32'h14, 1, 0, 32'h0);
        check("t5.hitflush.inst", inst, 32'h3333_0014);
        step(1, 1, 32'h14, 0, 0, 32'h0);
        check("t5.miss.stallreq", 32'(stallreq), 32'h1);
        step(1, 1, 32'h14, 1, 1, 32'h0BAD_0014);
        check("t5.req.mem_req", 32'(mem_req), 32'h1);
        step(1, 1, 32'h14, 0, 0, 32'h0);
        check("t5.discard.stallreq", 32'(stallreq), 32'h1);
        check("t5.discard.mem_req", 32'(mem_req), 32'h0);
        step(1, 1, 32'h14, 0, 1, 32'h4444_0014);
        step(1, 1, 32'h14, 0, 0, 32'h0);
        check("t5.final.inst", inst, 32'h4444_0014);

        // reset mid-fetch, then a stray ack while idle
        step(1, 1, 32'h18, 0, 0, 32'h0);
        step(1, 1, 32'h18, 0, 0, 32'h0);
        check("t6.req.mem_req", 32'(mem_req), 32'h1);
        step(0, 1, 32'h18, 0, 0, 32'h0);
        check("t6.rst.mem_req", 32'(mem_req), 32'h0);
        check("t6.rst.stallreq", 32'(stallreq), 32'h0);
        step(1, 0, 32'h18, 0, 1, 32'h0BAD_0018);
        check("t6.stray.mem_req", 32'(mem_req), 32'h0);
        step(1, 1, 32'h14, 0, 0, 32'h0);
        check("t6.lost_buffer.stallreq", 32'(stallreq), 32'h1);
        step(1, 1, 32'h14, 0, 1, 32'h5555_0014);
        step(1, 1, 32'h14, 0, 0, 32'h0);
        check("t6.refill.inst", inst, 32'h5555_0014);

        // randomized traffic over a small address window so hits are common
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            rr = ($urandom_range(0, 199) != 0);
            rc = ($urandom_range(0, 9) < 8);
            ra = (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            rf = ($urandom_range(0, 19) == 0);
            rk = mem_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 49) == 0);
            rst = rr; ce = rc; addr = ra; flush = rf; mem_ack = rk;
            mem_rdata = $urandom;
            @(negedge clk);
        end

        step(1, 0, 32'h0, 0, 0, 32'h0);
        step(1, 0, 32'h0, 0, 0, 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch_responder.md
Name: inst_fetch_responder

Overview:
- Instruction-side responder for the PC/fetch stage.
- Accepts the fetch address and chip-enable from the PC register and returns the instruction word from an external variable-latency memory bus.
- Holds a single-entry fetch buffer (last address/data) and raises a stall request to the pipeline control block while a miss is outstanding.
- Provides bounded-wait timeout and buffer invalidate (flush).

Parameters:
- TIMEOUT, 255, max cycles in a bus wait before abort; legal range 1..2^CNT_W-1.
- CNT_W, 8, wait-counter width.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- ce  input  1  fetch enable from PC register.
- addr  input  32  fetch address from PC register; bits [1:0] ignored.
- flush  input  1  invalidate fetch buffer / abandon outstanding fetch.
- inst  output  32  instruction to IF/ID.
- stallreq  output  1  stall request to pipeline control.
- fetch_err  output  1  current inst is a timeout substitute.
- mem_req  output  1  bus request, registered.
- mem_addr  output  32  bus word address, {req_addr[31:2],2'b00}, registered.
- mem_ack  input  1  bus data-valid strobe.
- mem_rdata  input  32  bus read data, valid with mem_ack.

Behaviour:
- Reset (rst=0, async): state=IDLE, buf_valid=0, buf_err=0, buf_addr=0, buf_data=0, req_addr=0, cnt=0, mem_req=0, mem_addr=0. stallreq=0, inst=0, fetch_err=0 while rst=0.
- hit = buf_valid && buf_addr[31:2]==addr[31:2] (combinational).
- Outputs (combinational from registers/inputs):
  - ce=0: inst=0, stallreq=0, fetch_err=0.
  - ce=1 and hit: inst=buf_data, fetch_err=buf_err, stallreq=0.
  - ce=1 and miss: inst=0, fetch_err=0, stallreq=1.
- FSM states: IDLE, REQ, DRAIN.
- IDLE: if ce && !hit && !flush -> REQ; latch req_addr=addr, cnt=0. mem_req=0. mem_ack in IDLE is ignored.
- REQ: mem_req=1 and mem_addr stable until exit; cnt increments each cycle.
  - mem_ack && !flush: buf_addr=req_addr, buf_data=mem_rdata, buf_valid=1, buf_err=0 -> IDLE.
  - mem_ack && flush: discard data -> IDLE.
  - flush && !mem_ack -> DRAIN; request is held, since the bus rule forbids withdrawing mem_req before ack.
  - cnt==TIMEOUT-1 && !mem_ack && !flush: buf_addr=req_addr, buf_data=0 (NOP), buf_valid=1, buf_err=1, mem_req drops -> IDLE.
- DRAIN: mem_req=1; on mem_ack or timeout, discard -> IDLE. Buffer is never written.
- flush in any state clears buf_valid and buf_err at that edge; flush has priority over any buffer fill in the same cycle.
- Simultaneous ack and timeout: ack wins.
- mem_req deasserts the cycle after ack is sampled (Moore output). The bus must not ack a dropped request.
- addr changing while in REQ does not alter req_addr. After return to IDLE, a new miss starts a new fetch. The stale fill is harmless.
- Minimum miss penalty: miss in cycle 0, mem_req in cycle 1, ack in cycle 1 gives a hit in cycle 2, so stallreq is high for exactly 2 cycles.
- Reset asserted mid-fetch: everything returns to reset values immediately; a later stray mem_ack is ignored in IDLE.

Test Plan:
- Reset release, ce=1, addr=0x0, memory returns 0x3401_0020 with zero wait: mem_req high in cycle 1 with mem_addr=0x0; stallreq=1 for cycles 0–1; cycle 2 inst=0x3401_0020, stallreq=0.
- addr held 0x4, ack delayed 5 cycles: stallreq high 7 cycles, mem_req high 6 cycles then low the cycle after ack; refetch of 0x4 later gives stallreq=0 (hit), no mem_req.
- TIMEOUT=4, no ack on addr 0x8: mem_req high exactly 4 cycles, then inst=0, fetch_err=1, stallreq=0; later addr=0xC clears fetch_err.
- flush pulsed on cycle 2 of REQ for addr 0x10, ack on cycle 4: mem_req held through ack, buffer not filled, next cycle stallreq=1 and a new request to 0x10 is issued.
- Buffer holds 0x14, flush with ce=1 addr=0x14 same cycle: next cycle miss, stallreq=1, new fetch; an ack coinciding with flush during REQ is discarded.
- rst pulsed low during REQ, then ack arrives while IDLE: no buffer write, mem_req=0, outputs at reset values.
